// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg
//   Shared definitions for the frame scan controller: FSM state encoding and
//   default datapath widths used by seq_scan_ctrl and pattern_detector.
package seq_scan_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_detector.sv
// pattern_detector
//   Bit-serial Moore detector for a PAT_W-bit pattern. Keeps the recent bit
//   history and a saturating fill count, so a hit needs PAT_W bits received
//   since the last clear (or since the last hit in non-overlap mode).
// Ports
//   clk, reset_n   clock, async active-low reset
//   i_bit_valid    i_bit is a new serial bit this cycle
//   i_bit          serial data bit
//   i_pattern      pattern to match, first-received bit at MSB
//   i_overlap      1 = overlapping matches, 0 = restart fill after a hit
//   i_clear        clear history and fill (frame start)
//   o_hit          combinational hit for the bit presented this cycle
//   o_match_tick   registered hit, one cycle after the bit
module pattern_detector #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_overlap,
  input  logic             i_clear,
  output logic             o_hit,
  output logic             o_match_tick
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_match_tick;

  logic [PAT_W-1:0]  w_hist;
  logic [FILL_W-1:0] w_fill;
  logic              w_hit;

  assign w_hist = {r_hist[PAT_W-2:0], i_bit};
  assign w_fill = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + FILL_W'(1);
  assign w_hit  = i_bit_valid && (w_hist == i_pattern) && (w_fill >= FILL_W'(PAT_W));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist       <= '0;
      r_fill       <= '0;
      r_match_tick <= 1'b0;
    end else if (i_clear) begin
      r_hist       <= '0;
      r_fill       <= '0;
      r_match_tick <= 1'b0;
    end else begin
      r_match_tick <= w_hit;
      if (i_bit_valid) begin
        r_hist <= w_hist;
        // Non-overlap: history is kept, but PAT_W fresh bits are required.
        r_fill <= (w_hit && !i_overlap) ? '0 : w_fill;
      end
    end
  end

  assign o_hit        = w_hit;
  assign o_match_tick = r_match_tick;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Accepts words over valid/ready and shifts each MSB-first into a
//   pattern_detector, one bit per clock. Counts detections per frame
//   (saturating) and pulses done after the last bit of the last word.
// Ports
//   clk, reset_n             clock, async active-low reset
//   start                    begin frame (IDLE only)
//   cfg_pattern, cfg_overlap detector config, latched on accepted start
//   word_in, word_valid,
//   word_last, word_ready    word handshake
//   busy                     frame in progress
//   match_tick               one pulse per detection
//   match_count              detections in current/last frame
//   done                     one pulse at frame end
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              busy,
  output logic              match_tick,
  output logic [CNT_W-1:0]  match_count,
  output logic              done
);

  localparam int BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t             r_state;
  logic [WORD_W-1:0]  r_shreg;
  logic               r_last;
  logic [BCNT_W-1:0]  r_bit_cnt;
  logic [PAT_W-1:0]   r_pattern;
  logic               r_overlap;
  logic               r_word_ready;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_match_count;

  logic w_start_ok;
  logic w_bit_valid;
  logic w_bit;
  logic w_hit;
  logic w_match_tick;

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_bit_valid = (r_state == ST_SHIFT);
  assign w_bit       = r_shreg[WORD_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_last       <= 1'b0;
      r_bit_cnt    <= '0;
      r_pattern    <= '0;
      r_overlap    <= 1'b0;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pattern    <= cfg_pattern;
            r_overlap    <= cfg_overlap;
            r_word_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (word_valid && r_word_ready) begin
            r_shreg      <= word_in;
            r_last       <= word_last;
            r_bit_cnt    <= '0;
            r_word_ready <= 1'b0;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shreg   <= r_shreg << 1;
          r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
          if (r_bit_cnt == BCNT_W'(WORD_W - 1)) begin
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_word_ready <= 1'b1;
              r_state      <= ST_ARM;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_word_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Count uses the detector's combinational hit so it lines up with match_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_match_count <= '0;
    end else if (w_start_ok) begin
      r_match_count <= '0;
    end else if (w_hit && (r_match_count != {CNT_W{1'b1}})) begin
      r_match_count <= r_match_count + CNT_W'(1);
    end
  end

  pattern_detector #(
    .PAT_W (PAT_W)
  ) u_det (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_bit_valid  (w_bit_valid),
    .i_bit        (w_bit),
    .i_pattern    (r_pattern),
    .i_overlap    (r_overlap),
    .i_clear      (w_start_ok),
    .o_hit        (w_hit),
    .o_match_tick (w_match_tick)
  );

  assign word_ready  = r_word_ready;
  assign busy        = r_busy;
  assign match_tick  = w_match_tick;
  assign match_count = r_match_count;
  assign done        = r_done;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic [7:0] word_in;
  logic       word_valid;
  logic       word_last;
  logic       word_ready;
  logic       busy;
  logic       match_tick;
  logic [7:0] match_count;
  logic       done;

  int tests = 0;
  int fails = 0;

  logic [7:0] words [0:63];

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_last   (word_last),
    .word_ready  (word_ready),
    .busy        (busy),
    .match_tick  (match_tick),
    .match_count (match_count),
    .done        (done)
  );

  // Reference: hits found by sliding a 4-bit window over the frame bit
  // stream; in non-overlap mode a window may not reuse bits of an earlier hit.
  // Cycle k counts edges after the start edge; with word_valid held high,
  // word w is taken at edge 9w+1, its bit j ticks at 9w+2+j, done at 9n.
  task automatic run_frame(input string name, input logic [3:0] pat, input bit ovl,
                           input int n, input bit noise, output int final_cnt);
    int   nb, last_end, kmax, cnt, w;
    logic bits [0:511];
    logic [3:0] win;
    logic [7:0] wd;
    bit   exp_tick [0:600];
    int   exp_cnt  [0:600];
    bit   exp_rdy, exp_busy, exp_done;

    nb   = n * 8;
    kmax = 9 * n + 1;
    for (int k = 0; k <= 600; k++) begin
      exp_tick[k] = 1'b0;
      exp_cnt[k]  = 0;
    end
    for (int i = 0; i < nb; i++) begin
      wd      = words[i / 8];
      bits[i] = wd[7 - (i % 8)];
    end
    last_end = -1;
    for (int i = 3; i < nb; i++) begin
      if (i - 3 > last_end) begin
        win = {bits[i-3], bits[i-2], bits[i-1], bits[i]};
        if (win == pat) begin
          exp_tick[9 * (i / 8) + 2 + (i % 8)] = 1'b1;
          if (!ovl) last_end = i;
        end
      end
    end
    cnt = 0;
    for (int k = 0; k <= kmax; k++) begin
      if (exp_tick[k] && cnt < 255) cnt++;
      exp_cnt[k] = cnt;
    end
    final_cnt = cnt;

    @(posedge clk); #1;
    start       = 1'b1;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    word_valid  = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (word_ready !== 1'b1 || busy !== 1'b1 || match_count !== 8'd0) begin
      fails++;
      $display("FAIL %s arm: rdy=%b busy=%b cnt=%0d, want 1 1 0", name, word_ready, busy, match_count);
    end
    start      = 1'b0;
    word_in    = words[0];
    word_last  = (n == 1);
    word_valid = 1'b1;

    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk); #1;
      exp_rdy  = (k % 9 == 0) && (k < 9 * n);
      exp_busy = (k <= 9 * n);
      exp_done = (k == 9 * n);
      tests++;
      if (match_tick !== exp_tick[k]) begin
        fails++;
        $display("FAIL %s tick k=%0d: got %b want %b", name, k, match_tick, exp_tick[k]);
      end
      tests++;
      if (match_count !== 8'(exp_cnt[k])) begin
        fails++;
        $display("FAIL %s count k=%0d: got %0d want %0d", name, k, match_count, exp_cnt[k]);
      end
      tests++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL %s done k=%0d: got %b want %b", name, k, done, exp_done);
      end
      tests++;
      if (word_ready !== exp_rdy || busy !== exp_busy) begin
        fails++;
        $display("FAIL %s rdy/busy k=%0d: got %b/%b want %b/%b", name, k, word_ready, busy, exp_rdy, exp_busy);
      end
      if (k % 9 == 1) begin
        w = (k - 1) / 9 + 1;
        if (w < n) begin
          word_in   = words[w];
          word_last = (w == n - 1);
        end else if (noise) begin
          word_in   = 8'($urandom);
          word_last = 1'($urandom);
        end else begin
          word_valid = 1'b0;
        end
      end
      start = (noise && (k % 9 != 0) && (k <= 9 * n - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start      = 1'b0;
    word_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (match_count !== 8'(cnt) || busy !== 1'b0 || word_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s hold: cnt=%0d busy=%b rdy=%b done=%b, want %0d 0 0 0", name, match_count, busy, word_ready, done, cnt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; cfg_pattern = 4'h0; cfg_overlap = 1'b0;
    word_in = 8'h00; word_valid = 1'b0; word_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({word_ready, busy, match_tick, match_count, done} !== 12'd0) begin
      fails++;
      $display("FAIL reset outputs: got %b/%b/%b/%0d/%b want all 0", word_ready, busy, match_tick, match_count, done);
    end
    reset_n = 1'b1;
    word_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (word_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle ignores valid: rdy=%b busy=%b want 0 0", word_ready, busy);
    end
    word_valid = 1'b0;
  endtask

  task automatic test_overlap();
    int c;
    words[0] = 8'hAA;
    run_frame("aa_ovl", 4'b1010, 1'b1, 1, 1'b0, c);
    tests++;
    if (match_count !== 8'd3) begin
      fails++;
      $display("FAIL aa_ovl total: got %0d want 3", match_count);
    end
  endtask

  task automatic test_no_overlap();
    int c;
    words[0] = 8'hAA;
    run_frame("aa_novl", 4'b1010, 1'b0, 1, 1'b0, c);
    tests++;
    if (match_count !== 8'd2) begin
      fails++;
      $display("FAIL aa_novl total: got %0d want 2", match_count);
    end
  endtask

  task automatic test_boundary();
    int c;
    words[0] = 8'h01;
    words[1] = 8'h80;
    run_frame("boundary", 4'b1100, 1'b1, 2, 1'b0, c);
    tests++;
    if (match_count !== 8'd1) begin
      fails++;
      $display("FAIL boundary total: got %0d want 1", match_count);
    end
  endtask

  task automatic test_saturation();
    int c;
    for (int i = 0; i < 40; i++) words[i] = 8'h00;
    run_frame("saturate", 4'b0000, 1'b1, 40, 1'b0, c);
    tests++;
    if (match_count !== 8'd255) begin
      fails++;
      $display("FAIL saturate total: got %0d want 255", match_count);
    end
  endtask

  task automatic test_reset_mid_shift();
    int c;
    @(posedge clk); #1;
    start = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; word_in = 8'h55; word_last = 1'b0; word_valid = 1'b1;
    @(posedge clk); #1;
    word_in = 8'h33;
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || word_ready !== 1'b0) begin
      fails++;
      $display("FAIL pre-reset shift: busy=%b rdy=%b want 1 0", busy, word_ready);
    end
    reset_n = 1'b0;
    #2;
    tests++;
    if ({word_ready, busy, match_tick, match_count, done} !== 12'd0) begin
      fails++;
      $display("FAIL mid-shift reset: got %b/%b/%b/%0d/%b want all 0", word_ready, busy, match_tick, match_count, done);
    end
    word_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    words[0] = 8'hAA;
    run_frame("post_reset", 4'b1010, 1'b1, 1, 1'b0, c);
    tests++;
    if (match_count !== 8'd3) begin
      fails++;
      $display("FAIL post_reset total: got %0d want 3", match_count);
    end
  endtask

  task automatic test_ignored_inputs();
    int c;
    words[0] = 8'hB6; words[1] = 8'hDB; words[2] = 8'h6D;
    run_frame("noise", 4'b1011, 1'b1, 3, 1'b1, c);
    run_frame("noise_ref", 4'b1011, 1'b1, 3, 1'b0, c);
  endtask

  task automatic test_random();
    int c, n;
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) words[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", f), 4'($urandom), 1'($urandom), n, 1'($urandom), c);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_boundary();
    test_saturation();
    test_reset_mid_shift();
    test_ignored_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
